// File: rtl/gcn_pkg.sv
// rtl/gcn_pkg.sv - shared sizes, FSM encoding, error bit indices and address helpers for the GCN result collector
package gcn_pkg;
    localparam int DATA_W = 16;
    localparam int N_ROWS = 100;
    localparam int N_COLS = 8;
    localparam int N_PASS = 4;
    localparam int ROW_W  = 7;
    localparam int COL_W  = 3;
    localparam int CNT_W  = 3;
    localparam int ADDR_W = $clog2(N_ROWS * N_COLS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COL_A = 2'd1;
    localparam logic [1:0] ST_COL_B = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int ERR_BAD_COL = 0;
    localparam int ERR_SHORT   = 1;
    localparam int ERR_OVERRUN = 2;

    function automatic logic [ADDR_W-1:0] buf_addr(input logic [ROW_W-1:0] row,
                                                   input logic [COL_W-1:0] col);
        return ADDR_W'(row) * ADDR_W'(N_COLS) + ADDR_W'(col);
    endfunction

    // Header columns are 8 bits wide; anything at or past N_COLS is not stored.
    function automatic logic col_in_range(input logic [7:0] col);
        return int'(col) < N_COLS;
    endfunction
endpackage

// File: rtl/gcn_result_ram.sv
// rtl/gcn_result_ram.sv - 1W1R synchronous result buffer, row-major, returns old data on a same-address collision
module gcn_result_ram
    import gcn_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [N_ROWS*N_COLS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/gcn_result_collector.sv
// rtl/gcn_result_collector.sv - captures GCN result passes into a column buffer with host read port; GCN_RES_RELU_EN clamps negative words to 0
module gcn_result_collector
    import gcn_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_rdy,
    input  logic              in_result,
    input  logic [DATA_W-1:0] in_data,
    input  logic              rd_en,
    input  logic [ROW_W-1:0]  rd_row,
    input  logic [COL_W-1:0]  rd_col,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_vld,
    output logic [N_COLS-1:0] col_vld,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic              all_done,
    output logic              busy,
    output logic [2:0]        err
);
    logic [1:0]        state;
    logic [ROW_W-1:0]  row;
    logic [7:0]        col_a;
    logic [7:0]        col_b;
    logic              beat;
    logic              last_row;
    logic              in_col_phase;
    logic [7:0]        wr_col;
    logic              we;
    logic [DATA_W-1:0] wr_word;
    logic              rd_in_range;
    logic              rd_ok;
    logic [DATA_W-1:0] ram_q;

    assign beat         = in_result & in_rdy;
    assign last_row     = (int'(row) == N_ROWS - 1);
    assign in_col_phase = (state == ST_COL_A) || (state == ST_COL_B);
    assign wr_col       = (state == ST_COL_B) ? col_b : col_a;
    assign we           = in_col_phase && beat && !clr && col_in_range(wr_col);
    assign rd_in_range  = (int'(rd_row) < N_ROWS) && (int'(rd_col) < N_COLS);

`ifdef GCN_RES_RELU_EN
    assign wr_word = in_data[DATA_W-1] ? '0 : in_data;
`else
    assign wr_word = in_data;
`endif

    gcn_result_ram u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (buf_addr(row, wr_col[COL_W-1:0])),
        .wdata (wr_word),
        .re    (rd_en && rd_in_range),
        .raddr (buf_addr(rd_row, rd_col)),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            row      <= '0;
            col_a    <= '0;
            col_b    <= '0;
            col_vld  <= '0;
            pass_cnt <= '0;
            err      <= '0;
        end else if (clr) begin
            state    <= ST_IDLE;
            row      <= '0;
            col_vld  <= '0;
            pass_cnt <= '0;
            err      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (beat) begin
                        col_a <= in_data[7:0];
                        col_b <= in_data[15:8];
                        row   <= '0;
                        state <= ST_COL_A;
                        if (!col_in_range(in_data[7:0]) || !col_in_range(in_data[15:8])) begin
                            err[ERR_BAD_COL] <= 1'b1;
                        end
                    end
                end
                ST_COL_A, ST_COL_B: begin
                    // Losing in_rdy mid-pass aborts; in_result low alone is a stall.
                    if (!in_rdy) begin
                        err[ERR_SHORT] <= 1'b1;
                        row            <= '0;
                        state          <= ST_IDLE;
                    end else if (in_result) begin
                        if (last_row) begin
                            row   <= '0;
                            state <= (state == ST_COL_A) ? ST_COL_B : ST_DONE;
                        end else begin
                            row <= row + 1'b1;
                        end
                    end
                end
                default: begin
                    if (col_in_range(col_a)) begin
                        col_vld[col_a[COL_W-1:0]] <= 1'b1;
                    end
                    if (col_in_range(col_b)) begin
                        col_vld[col_b[COL_W-1:0]] <= 1'b1;
                    end
                    if (int'(pass_cnt) != N_PASS) begin
                        pass_cnt <= pass_cnt + 1'b1;
                    end
                    if (beat) begin
                        err[ERR_OVERRUN] <= 1'b1;
                    end
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // rd_ok gates the unreset RAM output so out-of-range reads and reset return 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ok  <= 1'b0;
            rd_vld <= 1'b0;
        end else begin
            rd_vld <= rd_en && rd_in_range && col_vld[rd_col];
            if (rd_en) begin
                rd_ok <= rd_in_range;
            end
        end
    end

    assign rd_data  = rd_ok ? ram_q : '0;
    assign all_done = (int'(pass_cnt) == N_PASS);
    assign busy     = (state != ST_IDLE);
endmodule

// File: tb/tb_gcn_result_collector.sv
// tb/tb_gcn_result_collector.sv - self-checking bench with pass-level reference model for gcn_result_collector
module tb_gcn_result_collector;
    logic        clk = 1'b0;
    logic        rst, clr, in_rdy, in_result, rd_en;
    logic [15:0] in_data;
    logic [6:0]  rd_row;
    logic [2:0]  rd_col;
    logic [15:0] rd_data;
    logic        rd_vld;
    logic [7:0]  col_vld;
    logic [2:0]  pass_cnt;
    logic        all_done, busy;
    logic [2:0]  err;

    always #5 clk = ~clk;

    gcn_result_collector dut (
        .clk(clk), .rst(rst), .clr(clr), .in_rdy(in_rdy), .in_result(in_result),
        .in_data(in_data), .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col),
        .rd_data(rd_data), .rd_vld(rd_vld), .col_vld(col_vld), .pass_cnt(pass_cnt),
        .all_done(all_done), .busy(busy), .err(err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] pdata [200];
    logic [15:0] m_buf [100][8];
    logic [7:0]  m_vld;
    int          m_cnt;
    logic [2:0]  m_err;

    int          c_row, c_col;
    logic [15:0] c_exp;

    typedef struct {
        int          row;
        int          col;
        logic [15:0] d;
        bit          chk_d;
        logic        v;
    } rd_vec_t;
    rd_vec_t rtab[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] relu(input logic [15:0] w);
`ifdef GCN_RES_RELU_EN
        return w[15] ? 16'h0000 : w;
`else
        return w;
`endif
    endfunction

    // Pass-level model: the first nb beats land in column a (rows 0..99) then column b.
    task automatic m_writes(input logic [15:0] hdr, input int nb);
        int a = int'(hdr[7:0]);
        int b = int'(hdr[15:8]);
        for (int i = 0; i < nb; i++) begin
            int c = (i < 100) ? a : b;
            if (c < 8) m_buf[i % 100][c] = relu(pdata[i]);
        end
    endtask

    task automatic m_pass(input logic [15:0] hdr, input int nb, input bit ovr);
        int a = int'(hdr[7:0]);
        int b = int'(hdr[15:8]);
        m_writes(hdr, nb);
        if (a >= 8 || b >= 8) m_err[0] = 1'b1;
        if (nb < 200) begin
            m_err[1] = 1'b1;
        end else begin
            if (a < 8) m_vld[a] = 1'b1;
            if (b < 8) m_vld[b] = 1'b1;
            if (m_cnt < 4) m_cnt++;
            if (ovr) m_err[2] = 1'b1;
        end
    endtask

    task automatic m_clear();
        m_vld = '0;
        m_cnt = 0;
        m_err = '0;
    endtask

    task automatic send_pass(input logic [15:0] hdr, input int nb, input int stall_pct,
                             input bit ovr, input int coll);
        in_rdy = 1'b1; in_result = 1'b1; in_data = hdr;
        step();
        for (int i = 0; i < nb; i++) begin
            while (stall_pct > 0 && $urandom_range(99) < stall_pct) begin
                in_result = 1'b0; in_data = 16'($urandom);
                step();
            end
            in_result = 1'b1; in_data = pdata[i];
            if (i == coll) begin
                rd_en = 1'b1; rd_row = 7'(c_row); rd_col = 3'(c_col);
            end
            step();
            if (i == coll) begin
                rd_en = 1'b0;
                chk("collide_old_data", rd_data, c_exp);
            end
        end
        if (nb < 200 || !ovr) begin
            in_rdy = 1'b0; in_result = 1'b0;
        end
        step();
        in_rdy = 1'b0; in_result = 1'b0;
        step();
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_col_vld"}, col_vld, m_vld);
        chk({tag, "_pass_cnt"}, pass_cnt, m_cnt);
        chk({tag, "_err"}, err, m_err);
        chk({tag, "_all_done"}, all_done, (m_cnt == 4));
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic run_pass(input string tag, input logic [15:0] hdr, input int nb,
                            input int stall_pct, input bit ovr, input int coll);
        send_pass(hdr, nb, stall_pct, ovr, coll);
        m_pass(hdr, nb, ovr);
        chk_flags(tag);
    endtask

    task automatic do_read(input int r, input int c, output logic [15:0] d, output logic v);
        rd_en = 1'b1; rd_row = 7'(r); rd_col = 3'(c);
        step();
        rd_en = 1'b0;
        d = rd_data; v = rd_vld;
    endtask

    task automatic rand_data();
        for (int i = 0; i < 200; i++) pdata[i] = 16'($urandom);
    endtask

    task automatic pulse_clr();
        clr = 1'b1; step(); clr = 1'b0;
        m_clear();
    endtask

    initial begin
        logic [15:0] d;
        logic        v;
        logic [15:0] hdr;

        rst = 1'b0; clr = 1'b0; in_rdy = 1'b0; in_result = 1'b0; in_data = '0;
        rd_en = 1'b0; rd_row = '0; rd_col = '0;
        m_clear();
        repeat (3) step();
        chk("rst_col_vld", col_vld, 8'h00);
        chk("rst_pass_cnt", pass_cnt, 3'd0);
        chk("rst_err", err, 3'b000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_all_done", all_done, 1'b0);
        chk("rst_rd_vld", rd_vld, 1'b0);
        chk("rst_rd_data", rd_data, 16'h0000);
        rst = 1'b1;
        step();

        // Full pass, data = beat index.
        for (int i = 0; i < 200; i++) pdata[i] = 16'(i);
        run_pass("t1", 16'h0100, 200, 0, 1'b0, -1);
        chk("t1_col_vld_const", col_vld, 8'h03);
        chk("t1_pass_cnt_const", pass_cnt, 3'd1);
        rtab[0] = '{0,   0, 16'd0,   1'b1, 1'b1};
        rtab[1] = '{99,  0, 16'd99,  1'b1, 1'b1};
        rtab[2] = '{0,   1, 16'd100, 1'b1, 1'b1};
        rtab[3] = '{99,  1, 16'd199, 1'b1, 1'b1};
        rtab[4] = '{42,  1, 16'd142, 1'b1, 1'b1};
        rtab[5] = '{100, 0, 16'd0,   1'b1, 1'b0};
        rtab[6] = '{127, 1, 16'd0,   1'b1, 1'b0};
        rtab[7] = '{5,   2, 16'd0,   1'b0, 1'b0};
        for (int k = 0; k < 8; k++) begin
            do_read(rtab[k].row, rtab[k].col, d, v);
            if (rtab[k].chk_d) chk($sformatf("t1_rd_data[%0d]", k), d, rtab[k].d);
            chk($sformatf("t1_rd_vld[%0d]", k), v, rtab[k].v);
        end

        // Short pass: in_rdy drops after 150 data beats.
        rand_data();
        run_pass("t3", 16'h0302, 150, 10, 1'b0, -1);
        chk("t3_err_const", err, 3'b010);
        chk("t3_col_vld_const", col_vld, 8'h03);
        chk("t3_pass_cnt_const", pass_cnt, 3'd1);

        // clr together with a header beat: beat dropped, flags cleared, buffer kept.
        clr = 1'b1; in_rdy = 1'b1; in_result = 1'b1; in_data = 16'h0504;
        step();
        clr = 1'b0; in_rdy = 1'b0; in_result = 1'b0;
        m_clear();
        chk_flags("clr");
        do_read(99, 0, d, v);
        chk("clr_buf_kept", d, 16'd99);
        chk("clr_rd_vld", v, 1'b0);

        // Four passes with stalls; collision read during the first.
        c_row = 10; c_col = 0; c_exp = m_buf[10][0];
        rand_data();
        run_pass("t2a", 16'h0100, 200, 20, 1'b0, 10);
        rand_data();
        run_pass("t2b", 16'h0302, 200, 20, 1'b0, -1);
        rand_data();
        run_pass("t2c", 16'h0504, 200, 20, 1'b0, -1);
        rand_data();
        run_pass("t2d", 16'h0706, 200, 20, 1'b0, -1);
        chk("t2_all_done", all_done, 1'b1);
        chk("t2_col_vld_const", col_vld, 8'hFF);
        for (int r = 0; r < 100; r++) begin
            for (int c = 0; c < 8; c++) begin
                do_read(r, c, d, v);
                chk($sformatf("t2_rd[%0d][%0d]", r, c), d, m_buf[r][c]);
                chk($sformatf("t2_vld[%0d][%0d]", r, c), v, 1'b1);
            end
        end

        // Bad column 9: must not alias onto column 1.
        pulse_clr();
        rand_data();
        run_pass("t4", 16'h0900, 200, 0, 1'b0, -1);
        chk("t4_err_const", err, 3'b001);
        chk("t4_col_vld_const", col_vld, 8'h01);
        do_read(0, 1, d, v);  chk("t4_col1_r0", d, m_buf[0][1]);
        do_read(50, 1, d, v); chk("t4_col1_r50", d, m_buf[50][1]);
        do_read(99, 1, d, v); chk("t4_col1_r99", d, m_buf[99][1]);
        do_read(7, 0, d, v);  chk("t4_col0_r7", d, relu(pdata[7]));

        // Overrun beat in DONE plus col_a == col_b.
        pulse_clr();
        rand_data();
        run_pass("ovr", 16'h0505, 200, 0, 1'b1, -1);
        chk("ovr_err_const", err, 3'b100);
        chk("ovr_col_vld_const", col_vld, 8'h20);
        do_read(7, 5, d, v);
        chk("same_col_data", d, relu(pdata[107]));
        chk("same_col_vld", v, 1'b1);

        // Negative word storage.
        for (int i = 0; i < 200; i++) pdata[i] = 16'(i);
        pdata[0] = 16'h8005; pdata[100] = 16'h7FFF;
        run_pass("t5", 16'h0302, 200, 0, 1'b0, -1);
        do_read(0, 2, d, v);
`ifdef GCN_RES_RELU_EN
        chk("t5_relu_neg", d, 16'h0000);
`else
        chk("t5_raw_neg", d, 16'h8005);
`endif
        do_read(0, 3, d, v);
        chk("t5_pos", d, 16'h7FFF);

        // Reset at data beat 50, then a fresh pass.
        rand_data();
        hdr = 16'h0504;
        in_rdy = 1'b1; in_result = 1'b1; in_data = hdr;
        step();
        for (int i = 0; i < 50; i++) begin
            in_data = pdata[i];
            step();
        end
        rst = 1'b0;
        #1;
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_col_vld", col_vld, 8'h00);
        chk("t6_rst_pass_cnt", pass_cnt, 3'd0);
        chk("t6_rst_err", err, 3'b000);
        m_writes(hdr, 50);
        m_clear();
        in_rdy = 1'b0; in_result = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk_flags("t6_idle");
        rand_data();
        run_pass("t6", 16'h0302, 200, 0, 1'b0, -1);
        chk("t6_col_vld_const", col_vld, 8'h0C);
        chk("t6_pass_cnt_const", pass_cnt, 3'd1);
        chk("t6_err_const", err, 3'b000);
        do_read(10, 4, d, v);
        chk("t6_partial_data", d, m_buf[10][4]);
        chk("t6_partial_vld", v, 1'b0);

        // Randomized passes against the model.
        for (int p = 0; p < 8; p++) begin
            int nb;
            bit ovr;
            hdr = {8'($urandom_range(9)), 8'($urandom_range(9))};
            nb  = ($urandom_range(3) == 0) ? int'($urandom_range(199, 1)) : 200;
            ovr = 1'($urandom_range(1));
            rand_data();
            run_pass($sformatf("rnd%0d", p), hdr, nb, 15, ovr, -1);
        end
        for (int k = 0; k < 64; k++) begin
            int r = int'($urandom_range(110));
            int c = int'($urandom_range(7));
            do_read(r, c, d, v);
            chk($sformatf("rnd_rd[%0d][%0d]", r, c), d, (r < 100) ? m_buf[r][c] : 16'h0000);
            chk($sformatf("rnd_vld[%0d][%0d]", r, c), v, (r < 100) && m_vld[c]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
